seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Downstream consumer of the sensor block's BCD digits (dig1=ones .. dig4=thousands).
//  Time-multiplexes four common-anode 7-segment digits on the board display.
//  Double-buffered capture on a load strobe prevents tearing mid-frame.
//  Includes anti-ghost blanking between digits and a dash glyph for non-BCD nibbles.
// PARAMETERS
//  REFRESH_DIV  100000  clk cycles per digit slot (100 MHz -> 1 kHz/digit, 250 Hz frame); >= GHOST_CYC+2
//  GHOST_CYC    64      cycles at slot start with all anodes off (anti-ghost); >= 1
// PORTS
//  clk    in   1  system clock; all logic on rising edge
//  reset  in   1  synchronous, active-high reset
//  load   in   1  capture strobe for dig1..dig4 (1-cycle pulse or level; sampled every clk)
//  dig1   in   4  ones BCD digit
//  dig2   in   4  tens BCD digit
//  dig3   in   4  hundreds BCD digit
//  dig4   in   4  thousands BCD digit
//  seg    out  7  cathodes, active-low, {g,f,e,d,c,b,a}
//  an     out  4  anodes, active-low; an[0]=ones .. an[3]=thousands
//  dp     out  1  decimal point, active-low; constant 1 (off)
// BEHAVIOUR
//  - Reset (sync, active-high): seg=7'h7F, an=4'hF, dp=1; pending/active digit regs=0;
//    slot counter=0; digit index=0. Reset asserted mid-scan wins; state is reset at the next edge.
//  - Slot counter: 0..REFRESH_DIV-1, wraps to 0; at terminal count, index advances 0->1->2->3->0.
//  - Capture: load=1 writes dig1..dig4 into the pending regs at that edge.
//  - Frame swap: pending -> active at the edge where counter is terminal and index==3.
//    Simultaneous load at the swap edge: the incoming dig values go straight to active (bypass)
//    and to pending. The active value is never altered mid-frame.
//  - Anode: an = all 1s while counter < GHOST_CYC; else one-hot low at index.
//  - seg: active digit[index] decoded.
//    0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex, active-low).
//    Nibble >9 -> dash 7'h3F (g only). seg = 7'h7F while anodes are blanked.
//  - Latency: seg/an/dp are registered; each reflects counter/index one clk later
//    (the slot's first cycle after reset release shows an=F).
//  - Capture to display: a load reaches the pins at the first frame start after the load.
//    Worst case ~1 frame + 1 clk.
// CONFIGURATION
//  LEAD_ZERO_BLANK_EN defined:
//    thousands, hundreds and tens show seg=7'h7F when the digit is 0 and every higher digit is 0.
//    Ones is never blanked. A blanked digit keeps its anode low (timing unchanged).
//    A non-BCD higher digit counts as nonzero.
//  Undefined: all four digits always decoded (e.g. 0042 shows "0042").
// TESTING (bench params REFRESH_DIV=8, GHOST_CYC=2)
//  1. Reset held 3 clk, then released.
//     -> seg=7F, an=F, dp=1 during reset.
//     -> Slot 0: an=F for 2 clk, then an=E for 6 clk; an=D follows (after its 2-clk blank).
//  2. load=1 for 1 clk with dig4..1=1,2,3,4 early in frame 0.
//     -> Frame 0 still shows 0000.
//     -> Frame 1: an=E/seg=19, an=D/seg=30, an=B/seg=24, an=7/seg=79.
//  3. load pulse exactly at the swap edge with 9,8,7,6.
//     -> Next frame shows 9876 (bypass); no frame shows a mix of old and new digits.
//  4. dig2=4'hC loaded.
//     -> Tens slot seg=3F (dash); other digits decode normally.
//  5. LEAD_ZERO_BLANK_EN with digits 0,0,4,2.
//     -> Thousands and hundreds seg=7F, tens seg=19, ones seg=24.
//     -> Undefined build: thousands and hundreds seg=40.
//  6. Reset pulsed while index=2, counter=5.
//     -> Next clk: an=F, seg=7F, active regs=0; scan restarts at slot 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for four common-anode 7-segment digits.
// Digits are captured into a pending bank on load and copied to the active bank only at
// frame boundaries, so a frame never shows a mix of old and new digits.
// Optional feature macro: LEAD_ZERO_BLANK_EN (blank leading zeros of the upper three digits).
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GHOST_CYC   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    input  logic [3:0] dig4,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] GhostLim = CntW'(GHOST_CYC);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    // Index 0 = ones .. 3 = thousands
    logic [3:0][3:0] pend_q, pend_d;
    logic [3:0][3:0] act_q, act_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic            slot_end;
    logic            frame_end;
    logic            blank_lead;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F; // non-BCD nibble shows a dash
        endcase
        return s;
    endfunction

    // Slot counter and digit index advance
    always_comb begin
        slot_end  = (cnt_q == CntLast);
        cnt_d     = slot_end ? '0 : cnt_q + CntW'(1);
        idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
        frame_end = slot_end && (idx_q == 2'd3);
    end

    // Capture into pending; pending (including a same-edge load) moves to active at frame end
    always_comb begin
        pend_d = load ? {dig4, dig3, dig2, dig1} : pend_q;
        act_d  = frame_end ? pend_d : act_q;
    end

    // Leading-zero blanking of the currently scanned digit
    always_comb begin
`ifdef LEAD_ZERO_BLANK_EN
        case (idx_q)
            2'd3:    blank_lead = (act_q[3] == 4'd0);
            2'd2:    blank_lead = (act_q[3] == 4'd0) && (act_q[2] == 4'd0);
            2'd1:    blank_lead = (act_q[3] == 4'd0) && (act_q[2] == 4'd0) &&
                                  (act_q[1] == 4'd0);
            default: blank_lead = 1'b0;
        endcase
`else
        blank_lead = 1'b0;
`endif
    end

    // Anode / cathode next value: blanked during the ghost window, else the indexed digit
    always_comb begin
        if (cnt_q < GhostLim) begin
            an_d  = 4'hF;
            seg_d = 7'h7F;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = blank_lead ? 7'h7F : decode(act_q[idx_q]);
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            pend_q <= '0;
            act_q  <= '0;
            seg_q  <= 7'h7F;
            an_q   <= 4'hF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            pend_q <= pend_d;
            act_q  <= act_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with REFRESH_DIV=8, GHOST_CYC=2 (32-cycle frame).
// Expected pin values come from a time-based model (cycles since reset) and are queued at
// stimulus time; a monitor pops one entry per clock and compares.
module tb_seg7_scan_driver;

    localparam int DIV   = 8;
    localparam int GHOST = 2;
    localparam int FRAME = 4 * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] dig1 = 4'd0, dig2 = 4'd0, dig3 = 4'd0, dig4 = 4'd0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    seg7_scan_driver #(
        .REFRESH_DIV(DIV),
        .GHOST_CYC  (GHOST)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .dig1 (dig1),
        .dig2 (dig2),
        .dig3 (dig3),
        .dig4 (dig4),
        .seg  (seg),
        .an   (an),
        .dp   (dp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Model state: cycles since reset, pending digits and digits shown this frame
    int         m = 0;
    logic [3:0] md_pend[4];
    logic [3:0] md_act[4];
    logic [6:0] glyph[16];

    initial begin
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        for (int i = 0; i < 4; i++) begin
            md_pend[i] = 4'd0;
            md_act[i]  = 4'd0;
        end
    end

    function automatic bit lead_blank(input int slot);
        bit all_zero;
        all_zero = (slot != 0);
        for (int j = slot; j < 4; j++)
            if (md_act[j] != 4'd0) all_zero = 0;
`ifdef LEAD_ZERO_BLANK_EN
        return all_zero;
`else
        return 0;
`endif
    endfunction

    // One clock of stimulus; pushes what the pins should show after the coming edge
    task automatic tick(input bit rst, input bit ld,
                        input logic [3:0] d4, input logic [3:0] d3,
                        input logic [3:0] d2, input logic [3:0] d1);
        exp_t e;
        int   pos, slot;
        @(negedge clk);
        reset = rst;
        load  = ld;
        dig4  = d4; dig3 = d3; dig2 = d2; dig1 = d1;
        if (rst) begin
            e.an = 4'hF; e.seg = 7'h7F;
            m = 0;
            for (int i = 0; i < 4; i++) begin
                md_pend[i] = 4'd0;
                md_act[i]  = 4'd0;
            end
        end else begin
            pos  = m % DIV;
            slot = (m / DIV) % 4;
            if (pos < GHOST) begin
                e.an = 4'hF; e.seg = 7'h7F;
            end else begin
                e.an  = 4'hF & ~(4'b0001 << slot);
                e.seg = lead_blank(slot) ? 7'h7F : glyph[md_act[slot]];
            end
            if (ld) begin
                md_pend[0] = d1; md_pend[1] = d2; md_pend[2] = d3; md_pend[3] = d4;
            end
            if (m % FRAME == FRAME - 1)
                for (int i = 0; i < 4; i++) md_act[i] = md_pend[i];
            m++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic idle_until(input int frame_pos);
        while ((m % FRAME) != frame_pos) tick(0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    endtask

    // Monitor: one expected entry per clock, sampled 1 time unit after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (an !== e.an) begin
                    bad++;
                    $display("FAIL an t=%0t got=%h want=%h", $time, an, e.an);
                end
                total++;
                if (seg !== e.seg) begin
                    bad++;
                    $display("FAIL seg t=%0t got=%h want=%h", $time, seg, e.seg);
                end
                total++;
                if (dp !== 1'b1) begin
                    bad++;
                    $display("FAIL dp t=%0t got=%b want=1", $time, dp);
                end
            end
        end
    end

    initial begin
        logic [3:0] r[4];
        // Reset held 3 clocks
        for (int i = 0; i < 3; i++) tick(1, 0, 4'd0, 4'd0, 4'd0, 4'd0);
        // Early load of 1,2,3,4 in frame 0; frame 0 still shows 0000
        idle(3);
        tick(0, 1, 4'd1, 4'd2, 4'd3, 4'd4);
        idle_until(FRAME - 1);
        idle(FRAME);
        // Mid-frame load then an overriding load exactly at the swap edge (bypass)
        idle_until(10);
        tick(0, 1, 4'd5, 4'd5, 4'd5, 4'd5);
        idle_until(FRAME - 1);
        tick(0, 1, 4'd9, 4'd8, 4'd7, 4'd6);
        idle(FRAME);
        // Non-BCD tens digit
        tick(0, 1, 4'd5, 4'd0, 4'hC, 4'd7);
        idle_until(FRAME - 1);
        idle(FRAME + 1);
        // Leading zeros 0042
        tick(0, 1, 4'd0, 4'd0, 4'd4, 4'd2);
        idle_until(FRAME - 1);
        idle(FRAME + 1);
        // Randomized loads, zeros favoured to exercise blanking
        for (int c = 0; c < 8 * FRAME; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < 4; k++)
                    r[k] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                tick(0, 1, r[3], r[2], r[1], r[0]);
            end else begin
                tick(0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
            end
        end
        // Load non-zero digits, let them show, then reset at index 2, counter 5
        tick(0, 1, 4'd3, 4'd1, 4'd8, 4'd6);
        idle_until(FRAME - 1);
        idle(1);
        idle_until(2 * DIV + 5);
        tick(1, 0, 4'd0, 4'd0, 4'd0, 4'd0);
        idle(2 * FRAME);
        tick(0, 1, 4'd7, 4'd0, 4'd2, 4'd1);
        idle_until(FRAME - 1);
        idle(FRAME + 1);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
